// File: rtl/pspin_egress_dma_pkg.sv
// Shared egress/ingress DMA constants: completion error codes, beat geometry,
// the 4 KiB AXI boundary and the egress FSM state type.
package pspin_egress_dma_pkg;

   localparam logic [3:0] ERR_OK         = 4'd0;
   localparam logic [3:0] ERR_LEN_ZERO   = 4'd1;
   localparam logic [3:0] ERR_LEN_MTU    = 4'd2;
   localparam logic [3:0] ERR_UNALIGNED  = 4'd3;
   localparam logic [3:0] ERR_4K_CROSS   = 4'd4;
   localparam logic [3:0] ERR_RRESP      = 4'd5;
   localparam logic [3:0] ERR_BEAT_COUNT = 4'd6;

   // One AXI beat carries 2**BEAT_SHIFT bytes.
   localparam int BEAT_SHIFT  = 6;
   localparam int BEAT_BYTES  = 1 << BEAT_SHIFT;
   localparam int BOUNDARY_4K = 4096;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_STATUS
   } dma_state_e;

   // Number of beats needed to carry len bytes (11-bit arithmetic).
   function automatic logic [10:0] beats_of(input logic [10:0] len);
      return (len + 11'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
   endfunction

endpackage

// File: rtl/pspin_keep_gen.sv
// Byte-count to keep-mask decoder: the low byte_cnt lanes are enabled.
module pspin_keep_gen #(
   parameter int KEEP_WIDTH = 64,
   parameter int CNT_WIDTH  = 7
) (
   input  logic [CNT_WIDTH-1:0]  byte_cnt,
   output logic [KEEP_WIDTH-1:0] keep
);

   genvar gi;
   generate
      for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_keep
         // Lane gi is valid when it lies below the byte count.
         assign keep[gi] = (byte_cnt > CNT_WIDTH'(gi));
      end
   endgenerate

endmodule

// File: rtl/pspin_egress_dma.sv
// Egress DMA: takes one PsPIN descriptor at a time, reads the frame with a
// single AXI INCR burst and forwards the beats as an AXI-Stream frame to the
// NIC, then returns a tagged completion status.
module pspin_egress_dma
   import pspin_egress_dma_pkg::*;
#(
   parameter int AXIS_IF_DATA_WIDTH = 512,
   parameter int AXIS_IF_KEEP_WIDTH = AXIS_IF_DATA_WIDTH / 8,
   parameter int AXI_DATA_WIDTH     = 512,
   parameter int AXI_ADDR_WIDTH     = 32,
   parameter int AXI_ID_WIDTH       = 8,
   parameter int LEN_WIDTH          = 20,
   parameter int TAG_WIDTH          = 8,
   parameter int EGRESS_DMA_MTU     = 1500
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [AXI_ADDR_WIDTH-1:0]     read_desc_addr,
   input  logic [LEN_WIDTH-1:0]          read_desc_len,
   input  logic [TAG_WIDTH-1:0]          read_desc_tag,
   input  logic                          read_desc_valid,
   output logic                          read_desc_ready,
   output logic [TAG_WIDTH-1:0]          read_status_tag,
   output logic [3:0]                    read_status_error,
   output logic                          read_status_valid,
   input  logic                          read_status_ready,
   output logic [AXIS_IF_DATA_WIDTH-1:0] m_axis_pspin_tx_tdata,
   output logic [AXIS_IF_KEEP_WIDTH-1:0] m_axis_pspin_tx_tkeep,
   output logic                          m_axis_pspin_tx_tvalid,
   input  logic                          m_axis_pspin_tx_tready,
   output logic                          m_axis_pspin_tx_tlast,
   output logic                          m_axis_pspin_tx_tuser,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_pspin_awid,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_pspin_awaddr,
   output logic [7:0]                    m_axi_pspin_awlen,
   output logic [2:0]                    m_axi_pspin_awsize,
   output logic [1:0]                    m_axi_pspin_awburst,
   output logic                          m_axi_pspin_awlock,
   output logic [3:0]                    m_axi_pspin_awcache,
   output logic [2:0]                    m_axi_pspin_awprot,
   output logic                          m_axi_pspin_awvalid,
   input  logic                          m_axi_pspin_awready,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_pspin_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_pspin_wstrb,
   output logic                          m_axi_pspin_wlast,
   output logic                          m_axi_pspin_wvalid,
   input  logic                          m_axi_pspin_wready,
   input  logic [AXI_ID_WIDTH-1:0]       m_axi_pspin_bid,
   input  logic [1:0]                    m_axi_pspin_bresp,
   input  logic                          m_axi_pspin_bvalid,
   output logic                          m_axi_pspin_bready,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_pspin_arid,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_pspin_araddr,
   output logic [7:0]                    m_axi_pspin_arlen,
   output logic [2:0]                    m_axi_pspin_arsize,
   output logic [1:0]                    m_axi_pspin_arburst,
   output logic                          m_axi_pspin_arlock,
   output logic [3:0]                    m_axi_pspin_arcache,
   output logic [2:0]                    m_axi_pspin_arprot,
   output logic                          m_axi_pspin_arvalid,
   input  logic                          m_axi_pspin_arready,
   input  logic [AXI_ID_WIDTH-1:0]       m_axi_pspin_rid,
   input  logic [AXI_DATA_WIDTH-1:0]     m_axi_pspin_rdata,
   input  logic [1:0]                    m_axi_pspin_rresp,
   input  logic                          m_axi_pspin_rlast,
   input  logic                          m_axi_pspin_rvalid,
   output logic                          m_axi_pspin_rready
);

   localparam logic [BEAT_SHIFT:0] TAIL_FULL = (BEAT_SHIFT + 1)'(BEAT_BYTES);

   dma_state_e                    state_reg;
   logic                          desc_ready_reg;
   logic [AXI_ADDR_WIDTH-1:0]     addr_reg;
   logic [LEN_WIDTH-1:0]          len_reg;
   logic [TAG_WIDTH-1:0]          tag_reg;
   logic [10:0]                   beats_reg;
   logic [10:0]                   beat_cnt_reg;
   logic                          resp_err_reg;
   logic                          last_seen_reg;
   logic                          arvalid_reg;
   logic [AXIS_IF_DATA_WIDTH-1:0] tdata_reg;
   logic [AXIS_IF_KEEP_WIDTH-1:0] tkeep_reg;
   logic                          tvalid_reg;
   logic                          tlast_reg;
   logic                          tuser_reg;
   logic                          status_valid_reg;
   logic [3:0]                    status_err_reg;

   logic [3:0]                    desc_err;
   logic [10:0]                   arlen_full;
   logic [BEAT_SHIFT:0]           tail_bytes;
   logic [AXIS_IF_KEEP_WIDTH-1:0] tail_keep;
   logic                          r_hs;
   logic                          rresp_bad;
   logic                          beat_mismatch;

   // Descriptor sanity checks, first failing rule wins.
   always_comb begin
      desc_err = ERR_OK;
      if (read_desc_len == '0)
         desc_err = ERR_LEN_ZERO;
      else if (read_desc_len > LEN_WIDTH'(EGRESS_DMA_MTU))
         desc_err = ERR_LEN_MTU;
      else if (read_desc_addr[BEAT_SHIFT-1:0] != '0)
         desc_err = ERR_UNALIGNED;
      else if (({1'b0, read_desc_addr[11:0]} + 13'(read_desc_len)) > 13'(BOUNDARY_4K))
         desc_err = ERR_4K_CROSS;
   end

   assign arlen_full    = beats_reg - 11'd1;
   assign tail_bytes    = (len_reg[BEAT_SHIFT-1:0] == '0) ? TAIL_FULL
                                                          : {1'b0, len_reg[BEAT_SHIFT-1:0]};
   assign rresp_bad     = (m_axi_pspin_rresp != 2'b00);
   assign beat_mismatch = (beat_cnt_reg != arlen_full);
   assign m_axi_pspin_rready = (state_reg == ST_DATA) && !last_seen_reg &&
                               (!tvalid_reg || m_axis_pspin_tx_tready);
   assign r_hs = m_axi_pspin_rvalid && m_axi_pspin_rready;

   pspin_keep_gen #(
      .KEEP_WIDTH (AXIS_IF_KEEP_WIDTH),
      .CNT_WIDTH  (BEAT_SHIFT + 1)
   ) u_keep_gen (
      .byte_cnt (tail_bytes),
      .keep     (tail_keep)
   );

   // Command FSM with the one-entry stream output register folded in.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg        <= ST_IDLE;
         desc_ready_reg   <= 1'b0;
         addr_reg         <= '0;
         len_reg          <= '0;
         tag_reg          <= '0;
         beats_reg        <= '0;
         beat_cnt_reg     <= '0;
         resp_err_reg     <= 1'b0;
         last_seen_reg    <= 1'b0;
         arvalid_reg      <= 1'b0;
         tdata_reg        <= '0;
         tkeep_reg        <= '0;
         tvalid_reg       <= 1'b0;
         tlast_reg        <= 1'b0;
         tuser_reg        <= 1'b0;
         status_valid_reg <= 1'b0;
         status_err_reg   <= ERR_OK;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (desc_ready_reg && read_desc_valid) begin
                  desc_ready_reg <= 1'b0;
                  addr_reg       <= read_desc_addr;
                  len_reg        <= read_desc_len;
                  tag_reg        <= read_desc_tag;
                  beats_reg      <= beats_of(read_desc_len[10:0]);
                  beat_cnt_reg   <= '0;
                  resp_err_reg   <= 1'b0;
                  last_seen_reg  <= 1'b0;
                  status_err_reg <= desc_err;
                  if (desc_err != ERR_OK) begin
                     state_reg        <= ST_STATUS;
                     status_valid_reg <= 1'b1;
                  end else begin
                     state_reg   <= ST_ADDR;
                     arvalid_reg <= 1'b1;
                  end
               end else begin
                  desc_ready_reg <= 1'b1;
               end
            end
            ST_ADDR: begin
               if (m_axi_pspin_arready) begin
                  arvalid_reg <= 1'b0;
                  state_reg   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (r_hs) begin
                  tdata_reg    <= m_axi_pspin_rdata;
                  tvalid_reg   <= 1'b1;
                  tlast_reg    <= m_axi_pspin_rlast;
                  tkeep_reg    <= m_axi_pspin_rlast ? tail_keep : '1;
                  beat_cnt_reg <= beat_cnt_reg + 11'd1;
                  if (rresp_bad)
                     resp_err_reg <= 1'b1;
                  if (m_axi_pspin_rlast) begin
                     last_seen_reg <= 1'b1;
                     tuser_reg     <= resp_err_reg || rresp_bad || beat_mismatch;
                     if (beat_mismatch)
                        status_err_reg <= ERR_BEAT_COUNT;
                     else if (resp_err_reg || rresp_bad)
                        status_err_reg <= ERR_RRESP;
                     else
                        status_err_reg <= ERR_OK;
                  end else begin
                     tuser_reg <= 1'b0;
                  end
               end else if (tvalid_reg && m_axis_pspin_tx_tready) begin
                  tvalid_reg <= 1'b0;
                  if (tlast_reg) begin
                     tlast_reg        <= 1'b0;
                     tuser_reg        <= 1'b0;
                     status_valid_reg <= 1'b1;
                     state_reg        <= ST_STATUS;
                  end
               end
            end
            ST_STATUS: begin
               if (read_status_ready) begin
                  status_valid_reg <= 1'b0;
                  desc_ready_reg   <= 1'b1;
                  state_reg        <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign read_desc_ready        = desc_ready_reg;
   assign read_status_tag        = tag_reg;
   assign read_status_error      = status_err_reg;
   assign read_status_valid      = status_valid_reg;

   assign m_axis_pspin_tx_tdata  = tdata_reg;
   assign m_axis_pspin_tx_tkeep  = tkeep_reg;
   assign m_axis_pspin_tx_tvalid = tvalid_reg;
   assign m_axis_pspin_tx_tlast  = tlast_reg;
   assign m_axis_pspin_tx_tuser  = tuser_reg;

   assign m_axi_pspin_arid       = '0;
   assign m_axi_pspin_araddr     = addr_reg;
   assign m_axi_pspin_arlen      = arlen_full[7:0];
   assign m_axi_pspin_arsize     = 3'(BEAT_SHIFT);
   assign m_axi_pspin_arburst    = 2'b01;
   assign m_axi_pspin_arlock     = 1'b0;
   assign m_axi_pspin_arcache    = 4'b0011;
   assign m_axi_pspin_arprot     = 3'b000;
   assign m_axi_pspin_arvalid    = arvalid_reg;

   // The egress side never writes to PsPIN memory.
   assign m_axi_pspin_awid       = '0;
   assign m_axi_pspin_awaddr     = '0;
   assign m_axi_pspin_awlen      = '0;
   assign m_axi_pspin_awsize     = '0;
   assign m_axi_pspin_awburst    = '0;
   assign m_axi_pspin_awlock     = 1'b0;
   assign m_axi_pspin_awcache    = '0;
   assign m_axi_pspin_awprot     = '0;
   assign m_axi_pspin_awvalid    = 1'b0;
   assign m_axi_pspin_wdata      = '0;
   assign m_axi_pspin_wstrb      = '0;
   assign m_axi_pspin_wlast      = 1'b0;
   assign m_axi_pspin_wvalid     = 1'b0;
   assign m_axi_pspin_bready     = 1'b0;

   logic unused_inputs;
   assign unused_inputs = ^{m_axi_pspin_rid, m_axi_pspin_awready, m_axi_pspin_wready,
                            m_axi_pspin_bid, m_axi_pspin_bresp, m_axi_pspin_bvalid,
                            len_reg[LEN_WIDTH-1:BEAT_SHIFT], arlen_full[10:8]};

endmodule

// File: tb/tb_pspin_egress_dma.sv
// Self-checking bench for pspin_egress_dma: directed corner cases plus random
// descriptors, compared every cycle against a frame-level reference model.
module tb_pspin_egress_dma;

   logic          clk = 1'b0;
   logic          rstn;
   logic [31:0]   read_desc_addr;
   logic [19:0]   read_desc_len;
   logic [7:0]    read_desc_tag;
   logic          read_desc_valid;
   logic          read_desc_ready;
   logic [7:0]    read_status_tag;
   logic [3:0]    read_status_error;
   logic          read_status_valid;
   logic          read_status_ready;
   logic [511:0]  tdata;
   logic [63:0]   tkeep;
   logic          tvalid, tready, tlast, tuser;
   logic [7:0]    awid;
   logic [31:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awlock;
   logic [3:0]    awcache;
   logic [2:0]    awprot;
   logic          awvalid;
   logic [511:0]  wdata;
   logic [63:0]   wstrb;
   logic          wlast, wvalid, bready;
   logic [7:0]    arid;
   logic [31:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arlock;
   logic [3:0]    arcache;
   logic [2:0]    arprot;
   logic          arvalid, arready;
   logic [7:0]    rid;
   logic [511:0]  rdata;
   logic [1:0]    rresp;
   logic          rlast, rvalid, rready;

   always #5 clk = ~clk;

   pspin_egress_dma dut (
      .clk(clk), .rstn(rstn),
      .read_desc_addr(read_desc_addr), .read_desc_len(read_desc_len),
      .read_desc_tag(read_desc_tag), .read_desc_valid(read_desc_valid),
      .read_desc_ready(read_desc_ready),
      .read_status_tag(read_status_tag), .read_status_error(read_status_error),
      .read_status_valid(read_status_valid), .read_status_ready(read_status_ready),
      .m_axis_pspin_tx_tdata(tdata), .m_axis_pspin_tx_tkeep(tkeep),
      .m_axis_pspin_tx_tvalid(tvalid), .m_axis_pspin_tx_tready(tready),
      .m_axis_pspin_tx_tlast(tlast), .m_axis_pspin_tx_tuser(tuser),
      .m_axi_pspin_awid(awid), .m_axi_pspin_awaddr(awaddr), .m_axi_pspin_awlen(awlen),
      .m_axi_pspin_awsize(awsize), .m_axi_pspin_awburst(awburst), .m_axi_pspin_awlock(awlock),
      .m_axi_pspin_awcache(awcache), .m_axi_pspin_awprot(awprot), .m_axi_pspin_awvalid(awvalid),
      .m_axi_pspin_awready(1'b0),
      .m_axi_pspin_wdata(wdata), .m_axi_pspin_wstrb(wstrb), .m_axi_pspin_wlast(wlast),
      .m_axi_pspin_wvalid(wvalid), .m_axi_pspin_wready(1'b0),
      .m_axi_pspin_bid(8'd0), .m_axi_pspin_bresp(2'b00), .m_axi_pspin_bvalid(1'b0),
      .m_axi_pspin_bready(bready),
      .m_axi_pspin_arid(arid), .m_axi_pspin_araddr(araddr), .m_axi_pspin_arlen(arlen),
      .m_axi_pspin_arsize(arsize), .m_axi_pspin_arburst(arburst), .m_axi_pspin_arlock(arlock),
      .m_axi_pspin_arcache(arcache), .m_axi_pspin_arprot(arprot), .m_axi_pspin_arvalid(arvalid),
      .m_axi_pspin_arready(arready),
      .m_axi_pspin_rid(rid), .m_axi_pspin_rdata(rdata), .m_axi_pspin_rresp(rresp),
      .m_axi_pspin_rlast(rlast), .m_axi_pspin_rvalid(rvalid), .m_axi_pspin_rready(rready)
   );

   typedef struct {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
      logic         u;
      logic         kchk;
   } beat_t;

   typedef struct {
      logic [511:0] d;
      logic [1:0]   resp;
      logic         last;
   } rbeat_t;

   int      checks = 0;
   int      failures = 0;

   // model state for the descriptor in flight
   beat_t   exp_q[$];
   logic    in_flight = 1'b0;
   int      exp_err;
   logic [7:0]  exp_tag;
   logic    exp_ar;
   logic [31:0] exp_araddr;
   logic [7:0]  exp_arlen;
   int      exp_beats_total;

   // observations
   int      ar_seen, beats_seen, stall_cnt, stat_cycles;
   logic    done;
   logic [7:0]  last_arlen, last_tag;
   logic [63:0] last_keep;
   logic    last_user;
   logic [3:0]  last_err;

   // slave / sink knobs
   int      err_beat = -1;
   int      early_last = 0;
   int      tready_mode = 0;
   int      stat_hold = 0;

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] data_of(input logic [31:0] a, input int i);
      logic [511:0] d;
      for (int w = 0; w < 16; w++)
         d[w*32 +: 32] = a ^ (32'(i) << 16) ^ (32'(w) * 32'h0101_0101);
      return d;
   endfunction

   function automatic logic [63:0] keep_of(input int n);
      logic [127:0] m;
      m = (128'd1 << n) - 128'd1;
      return m[63:0];
   endfunction

   // ---------------- AXI read slave, stream sink, status sink ----------------
   initial begin
      rbeat_t rq[$];
      rbeat_t rb;
      logic s_ar, s_r, s_stat;
      logic [31:0] s_addr;
      logic [7:0]  s_len;
      int n, scnt;
      arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = 0;
      tready = 0; read_status_ready = 0; scnt = 0;
      forever begin
         @(negedge clk);
         s_ar = arvalid && arready; s_r = rvalid && rready; s_stat = read_status_valid;
         s_addr = araddr; s_len = arlen;
         @(posedge clk); #1;
         if (!rstn) begin
            rq.delete(); rvalid = 0; arready = 0; read_status_ready = 0; scnt = 0;
         end else begin
            if (s_r) void'(rq.pop_front());
            if (s_ar) begin
               n = int'(s_len) + 1;
               if (early_last > 0) n = early_last;
               for (int i = 0; i < n; i++) begin
                  rb.d = data_of(s_addr, i);
                  rb.resp = (i == err_beat) ? 2'b10 : 2'b00;
                  rb.last = (i == n - 1);
                  rq.push_back(rb);
               end
            end
            if (!(rvalid && !s_r))
               rvalid = (rq.size() > 0) && ($urandom_range(0, 3) != 0);
            if (rq.size() > 0) begin
               rdata = rq[0].d; rresp = rq[0].resp; rlast = rq[0].last;
            end
            arready = ($urandom_range(0, 2) != 0);
            case (tready_mode)
               1:       tready = 1'b1;
               2:       tready = !tready;
               default: tready = ($urandom_range(0, 3) != 0);
            endcase
            if (s_stat) begin
               read_status_ready = (scnt >= stat_hold);
               scnt++;
            end else begin
               scnt = 0;
               read_status_ready = (stat_hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   logic         prev_stall = 1'b0;
   logic [511:0] p_d;
   logic [63:0]  p_k;
   logic         p_l, p_u;
   beat_t        cb;

   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_tvalid", tvalid, 1'b1);
            check("stall_tdata", tdata, p_d);
            check("stall_tkeep", tkeep, p_k);
            check("stall_tlast_tuser", {tlast, tuser}, {p_l, p_u});
         end
         if (in_flight && exp_err >= 1 && exp_err <= 4)
            check("no_traffic_on_bad_desc", {arvalid, tvalid}, 2'b00);
         if (arvalid && arready) begin
            ar_seen++;
            last_arlen = arlen;
            check("ar_expected", exp_ar && in_flight, 1'b1);
            check("araddr", araddr, exp_araddr);
            check("arlen", arlen, exp_arlen);
            check("ar_fixed_fields", {arid, arsize, arburst, arlock, arcache, arprot},
                  {8'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000});
         end
         if (tvalid && tready) begin
            beats_seen++;
            last_keep = tkeep;
            last_user = tuser;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1'b1, 1'b0);
            end else begin
               cb = exp_q.pop_front();
               check("tdata", tdata, cb.d);
               if (cb.kchk) check("tkeep", tkeep, cb.k);
               check("tlast", tlast, cb.l);
               check("tuser", tuser, cb.u);
            end
         end
         if (in_flight && tvalid && !tready) stall_cnt++;
         if (read_status_valid) begin
            stat_cycles++;
            check("status_expected", in_flight, 1'b1);
            check("desc_ready_in_status", read_desc_ready, 1'b0);
            check("status_tag", read_status_tag, exp_tag);
            check("status_error", read_status_error, 4'(exp_err));
            if (read_status_ready) begin
               check("beats_left_at_status", exp_q.size(), 0);
               last_err = read_status_error;
               last_tag = read_status_tag;
               done = 1'b1;
               in_flight = 1'b0;
            end
         end
         prev_stall = tvalid && !tready;
         p_d = tdata; p_k = tkeep; p_l = tlast; p_u = tuser;
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue_desc(input logic [31:0] a, input logic [19:0] l, input logic [7:0] t,
                             input int eb, input int early);
      int e, nb, cnt, li;
      beat_t b;
      logic acc;
      li = int'(l);
      e = 0;
      if (li == 0) e = 1;
      else if (li > 1500) e = 2;
      else if (a[5:0] != 6'd0) e = 3;
      else if (int'(a[11:0]) + li > 4096) e = 4;
      exp_q.delete();
      ar_seen = 0; beats_seen = 0; stall_cnt = 0; stat_cycles = 0; done = 1'b0;
      exp_ar = 1'b0; exp_beats_total = 0; exp_araddr = 0; exp_arlen = 0;
      if (e == 0) begin
         nb = (li + 63) / 64;
         exp_ar = 1'b1; exp_araddr = a; exp_arlen = 8'(nb - 1);
         cnt = (early > 0) ? early : nb;
         for (int i = 0; i < cnt; i++) begin
            b.d = data_of(a, i);
            b.l = (i == cnt - 1);
            b.k = (i == nb - 1) ? keep_of(li - 64 * (nb - 1)) : '1;
            b.kchk = !(early > 0 && i == cnt - 1);
            b.u = b.l && ((early > 0) || (eb >= 0 && eb < nb));
            exp_q.push_back(b);
         end
         if (early > 0) e = 6;
         else if (eb >= 0 && eb < nb) e = 5;
         exp_beats_total = cnt;
      end
      exp_err = e; exp_tag = t; err_beat = eb; early_last = early; in_flight = 1'b1;
      read_desc_addr = a; read_desc_len = l; read_desc_tag = t; read_desc_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = read_desc_ready;
         @(posedge clk); #1;
      end
      read_desc_valid = 1'b0;
      check("desc_accepted", acc, 1'b1);
   endtask

   task automatic run_desc(input logic [31:0] a, input logic [19:0] l, input logic [7:0] t,
                           input int eb, input int early);
      issue_desc(a, l, t, eb, early);
      for (int c = 0; c < 3000 && !done; c++) @(negedge clk);
      check("status_within_budget", done, 1'b1);
      check("ar_count", ar_seen, exp_ar ? 1 : 0);
      check("beat_count", beats_seen, exp_beats_total);
      $display("desc addr=%08h len=%0d tag=%02h -> beats=%0d err=%0d", a, l, t, beats_seen, last_err);
      if (!done) begin
         rstn = 1'b0; in_flight = 1'b0;
         repeat (2) @(posedge clk);
         rstn = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] ra;
      logic [19:0] rl;
      int reb;
      rstn = 1'b0;
      read_desc_addr = '0; read_desc_len = '0; read_desc_tag = '0; read_desc_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {read_desc_ready, arvalid, rready, tvalid, tlast, tuser, read_status_valid, read_status_error},
            11'd0);
      @(negedge clk); rstn = 1'b1;
      #1 check("desc_ready_before_first_edge", read_desc_ready, 1'b0);
      @(posedge clk); #1;
      check("desc_ready_after_first_edge", read_desc_ready, 1'b1);

      // single-beat frame
      tready_mode = 1; stat_hold = 0;
      run_desc(32'h1000_0000, 20'd64, 8'hA5, -1, 0);
      check("t1_arlen", last_arlen, 8'd0);
      check("t1_keep", last_keep, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t1_beats", beats_seen, 1);
      check("t1_err_tag", {last_err, last_tag}, {4'd0, 8'hA5});

      // MTU-size frame
      run_desc(32'h1000_0040, 20'd1500, 8'h3C, -1, 0);
      check("t2_arlen", last_arlen, 8'd23);
      check("t2_beats", beats_seen, 24);
      check("t2_last_keep", last_keep, 64'h0000_0000_0FFF_FFFF);
      check("t2_err", last_err, 4'd0);

      // alternating backpressure
      tready_mode = 2;
      run_desc(32'h1000_0040, 20'd1500, 8'h11, -1, 0);
      check("t3_beats", beats_seen, 24);
      check("t3_stalls_seen", stall_cnt > 0, 1'b1);

      // descriptor rejections
      tready_mode = 0;
      run_desc(32'h1000_0000, 20'd0, 8'h01, -1, 0);
      check("t4_len0", last_err, 4'd1);
      run_desc(32'h1000_0000, 20'd1501, 8'h02, -1, 0);
      check("t4_mtu", last_err, 4'd2);
      run_desc(32'h1000_0004, 20'd64, 8'h03, -1, 0);
      check("t4_align", last_err, 4'd3);
      run_desc(32'h1000_0FC0, 20'd128, 8'h04, -1, 0);
      check("t4_4k", last_err, 4'd4);

      // slave error on beat 3 of 10
      run_desc(32'h1000_0000, 20'd640, 8'h55, 2, 0);
      check("t5_beats", beats_seen, 10);
      check("t5_tuser_last", last_user, 1'b1);
      check("t5_err", last_err, 4'd5);

      // rlast after 4 of 10 beats
      run_desc(32'h1000_0000, 20'd640, 8'h66, -1, 4);
      check("t5b_beats", beats_seen, 4);
      check("t5b_err", last_err, 4'd6);

      // completion held off for 20 cycles
      stat_hold = 20;
      run_desc(32'h1000_0080, 20'd200, 8'h77, -1, 0);
      check("t6_status_held", stat_cycles >= 21, 1'b1);
      stat_hold = 0;

      // reset in the middle of a frame
      tready_mode = 1;
      issue_desc(32'h1000_0000, 20'd1500, 8'h88, -1, 0);
      for (int c = 0; c < 500 && beats_seen < 5; c++) @(negedge clk);
      check("t7_frame_started", beats_seen >= 5, 1'b1);
      #2 rstn = 1'b0;
      in_flight = 1'b0;
      exp_q.delete();
      #1 check("t7_reset_outputs",
               {read_desc_ready, arvalid, rready, tvalid, tlast, tuser, read_status_valid, read_status_error},
               11'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      check("t7_desc_ready_after_reset", read_desc_ready, 1'b1);
      check("t7_no_tail", {tvalid, tlast}, 2'b00);
      $display("reset mid-frame after %0d beats", beats_seen);

      // random descriptors
      for (int n = 0; n < 25; n++) begin
         ra = 32'h2000_0000 | (32'($urandom_range(0, 63)) << 6);
         if ($urandom_range(0, 7) == 0) ra[5:0] = 6'($urandom_range(1, 63));
         rl = 20'($urandom_range(1, 1500));
         if ($urandom_range(0, 9) == 0) rl = 20'($urandom_range(1501, 4000));
         reb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 23)) : -1;
         tready_mode = int'($urandom_range(0, 2));
         stat_hold = int'($urandom_range(0, 3));
         run_desc(ra, rl, 8'($urandom), reb, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pspin_egress_dma.md
PSPIN_EGRESS_DMA -- requirements
Module: pspin_egress_dma

Interface
REQ-001 SHALL have parameter AXIS_IF_DATA_WIDTH, default 512: width of the TX stream data bus.
REQ-002 SHALL have parameter AXIS_IF_KEEP_WIDTH, default AXIS_IF_DATA_WIDTH/8: width of the TX stream byte-keep bus.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 512: width of the PsPIN read data bus; it SHALL equal AXIS_IF_DATA_WIDTH.
REQ-004 SHALL have parameter AXI_ADDR_WIDTH, default 32: width of the PsPIN address bus.
REQ-005 SHALL have parameter AXI_ID_WIDTH, default 8: width of the AXI ID fields.
REQ-006 SHALL have parameters LEN_WIDTH, default 20, and TAG_WIDTH, default 8: widths of the descriptor length and tag fields.
REQ-007 SHALL have parameter EGRESS_DMA_MTU, default 1500: the maximum frame length in bytes.
REQ-008 SHALL have port clk, input, width 1: the single clock.
REQ-009 SHALL have port rstn, input, width 1: reset, asynchronous and active-low.
REQ-010 SHALL have ports read_desc_addr/len/tag, inputs, widths AXI_ADDR_WIDTH/LEN_WIDTH/TAG_WIDTH: the egress command from PsPIN.
REQ-011 SHALL have ports read_desc_valid (input, width 1) and read_desc_ready (output, width 1): the command handshake.
REQ-012 SHALL have ports m_axis_pspin_tx_tdata/tkeep/tvalid/tlast/tuser, outputs, widths DATA/KEEP/1/1/1, plus m_axis_pspin_tx_tready, input, width 1: the TX frame toward the NIC; tuser=1 marks a bad frame.
REQ-013 SHALL have ports m_axi_pspin_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid, outputs, plus m_axi_pspin_arready, input: the read address channel.
REQ-014 SHALL have ports m_axi_pspin_rid/rdata/rresp/rlast/rvalid, inputs, plus m_axi_pspin_rready, output: the read data channel.
REQ-015 SHALL have all m_axi_pspin_aw*, w*, and bready ports present and driven 0: the write channels are unused.
REQ-016 SHALL have ports read_status_tag (output, TAG_WIDTH), read_status_error (output, 4), read_status_valid (output, 1), and read_status_ready (input, 1): the completion returned to PsPIN.

Function
REQ-017 SHALL be a four-state FSM: IDLE -> ADDR -> DATA -> STATUS -> IDLE.
  - read_desc_ready=1 only in IDLE.
  - A descriptor is accepted in IDLE when read_desc_valid=1; addr, len and tag are latched.
REQ-018 SHALL check the accepted descriptor in priority order and, on failure, go straight to STATUS with no AXI or stream traffic:
  - len==0 -> error 1.
  - len>EGRESS_DMA_MTU -> error 2.
  - addr[5:0]!=0 -> error 3.
  - burst crosses a 4 KiB boundary -> error 4.
REQ-019 SHALL enter ADDR the cycle after a valid accept and assert arvalid in that cycle; fields:
  - beats=ceil(len/64); arlen=beats-1, with 11-bit internal arithmetic.
  - arsize=3'd6, arburst=INCR, arid=0, arcache=4'b0011, arlock=0, arprot=0.
  - arvalid holds until arready, then the FSM moves to DATA.
REQ-020 SHALL, in DATA, pass R beats through a one-entry output register:
  - rready = !tvalid || tready.
  - tdata = rdata.
  - tkeep = all ones, except on the final beat, where the low (len mod 64, or 64 if 0) bits are set.
  - tlast = rlast.
REQ-021 SHALL handle a nonzero rresp on any beat as follows:
  - The frame completes normally.
  - tuser=1 on the tlast beat.
  - Status error=5.
REQ-022 SHALL handle rlast arriving on a beat count different from beats by forcing tlast on that beat, setting tuser=1, and reporting error=6.
REQ-023 SHALL move from DATA to STATUS when the tlast beat is handshaked on the stream; stream output signals SHALL hold stable while tvalid=1 and tready=0.
REQ-024 SHALL, in STATUS, hold read_status_valid=1 with the latched tag and error (0 = success) until read_status_ready=1, then return to IDLE.
REQ-025 SHALL allow at most one command in flight; a back-to-back command is accepted at the earliest in the cycle after the status handshake.

Reset
REQ-026 SHALL, while rstn=0, drive state=IDLE, read_desc_ready=0, arvalid=0, rready=0, tvalid=0, tlast=0, tuser=0, read_status_valid=0, read_status_error=0, and all latched fields to 0.
REQ-027 SHALL, on reset assertion mid-frame, abandon the frame with no trailing tlast; the outstanding AXI burst is not drained.
REQ-028 SHALL raise read_desc_ready in the first clock after rstn deasserts.

Structure
REQ-029 SHALL place the following constants in a shared package, reused by the ingress side: error codes 0-6, the beat-size shift (6), and the 4 KiB boundary constant.
REQ-030 SHALL implement the keep-mask generator as one sub-module, pspin_keep_gen, mapping a byte count to tkeep.

Verification
REQ-031 SHALL cover: desc addr=0x1000_0000, len=64 -> one AR with arlen=0; one beat with tkeep all ones and tlast; status error=0 with tag echoed.
REQ-032 SHALL cover: len=1500 at addr 0x1000_0040 -> arlen=23; 24 beats; last tkeep=0x0FFF_FFFF (low 28 bytes); error=0.
REQ-033 SHALL cover: tready toggling 1/0 every cycle during a 24-beat frame -> no beat lost or duplicated, and outputs stable while stalled.
REQ-034 SHALL cover: len=0, len=1501, addr=0x...0004, and addr=0x...0FC0 with len=128 -> errors 1/2/3/4, with no arvalid and no tvalid.
REQ-035 SHALL cover: rresp=2'b10 on beat 3 of 10 -> 10 beats, tuser=1 on the last beat, error=5.
REQ-036 SHALL cover: read_status_ready held 0 for 20 cycles -> status stable and read_desc_ready=0 throughout; rstn pulsed mid-frame -> all outputs return to reset values immediately.
